// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file's single write port between
// an ALU writeback source (0) and a load writeback source (1). Each source owns
// a one-entry holding buffer; buffered entries are granted round-robin into a
// registered write stage, and a pending-write bitmap is exported for hazards.
//
// Handshake: a request transfers on a rising clock edge where ReqValidN and
// ReqReadyN are both 1. ReqReadyN depends only on internal buffer state (never
// on ReqValid/ReqAddr), so a source must hold valid/addr/data stable until the
// transfer edge. A request to r0 completes the handshake but is discarded.
module regfile_write_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                       Clock,
   input  logic                       Reset,
   input  logic                       ReqValid0,
   input  logic [ADDR_WIDTH-1:0]      ReqAddr0,
   input  logic [DATA_WIDTH-1:0]      ReqData0,
   output logic                       ReqReady0,
   input  logic                       ReqValid1,
   input  logic [ADDR_WIDTH-1:0]      ReqAddr1,
   input  logic [DATA_WIDTH-1:0]      ReqData1,
   output logic                       ReqReady1,
   output logic [ADDR_WIDTH-1:0]      WriteAddr,
   output logic [DATA_WIDTH-1:0]      WriteData,
   output logic                       RegWrite,
   output logic [2**ADDR_WIDTH-1:0]   Busy,
   output logic [CNT_WIDTH-1:0]       ConflictCount
);

   localparam int NREG = 2**ADDR_WIDTH;

   // holding buffers
   logic                  r_buf0_v;
   logic [ADDR_WIDTH-1:0] r_buf0_addr;
   logic [DATA_WIDTH-1:0] r_buf0_data;
   logic                  r_buf1_v;
   logic [ADDR_WIDTH-1:0] r_buf1_addr;
   logic [DATA_WIDTH-1:0] r_buf1_data;

   // arbitration and write stage
   logic                  r_rr;
   logic                  r_reg_write;
   logic [ADDR_WIDTH-1:0] r_write_addr;
   logic [DATA_WIDTH-1:0] r_write_data;
   logic [CNT_WIDTH-1:0]  r_conflict_cnt;

   logic                  w_grant0;
   logic                  w_grant1;
   logic                  w_take0;
   logic                  w_take1;
   logic [NREG-1:0]       w_busy;

   // Grant comes from buffer state only; Rr breaks the tie when both are full.
   assign w_grant0  = r_buf0_v && (!r_buf1_v || !r_rr);
   assign w_grant1  = r_buf1_v && (!r_buf0_v ||  r_rr);

   // A buffer can take a new request if it is empty or is draining this cycle.
   assign ReqReady0 = !r_buf0_v || w_grant0;
   assign ReqReady1 = !r_buf1_v || w_grant1;

   assign w_take0   = ReqValid0 && ReqReady0;
   assign w_take1   = ReqValid1 && ReqReady1;

   // Source 0 buffer: load accepted requests, drop r0 writes, free on grant.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_buf0_v    <= 1'b0;
         r_buf0_addr <= '0;
         r_buf0_data <= '0;
      end else if (w_take0) begin
         r_buf0_v <= (ReqAddr0 != '0);
         if (ReqAddr0 != '0) begin
            r_buf0_addr <= ReqAddr0;
            r_buf0_data <= ReqData0;
         end
      end else if (w_grant0) begin
         r_buf0_v <= 1'b0;
      end
   end

   // Source 1 buffer: same behaviour as source 0.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_buf1_v    <= 1'b0;
         r_buf1_addr <= '0;
         r_buf1_data <= '0;
      end else if (w_take1) begin
         r_buf1_v <= (ReqAddr1 != '0);
         if (ReqAddr1 != '0) begin
            r_buf1_addr <= ReqAddr1;
            r_buf1_data <= ReqData1;
         end
      end else if (w_grant1) begin
         r_buf1_v <= 1'b0;
      end
   end

   // Write stage: capture the granted entry; address/data hold when idle.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_reg_write  <= 1'b0;
         r_write_addr <= '0;
         r_write_data <= '0;
      end else begin
         r_reg_write <= w_grant0 || w_grant1;
         if (w_grant1) begin
            r_write_addr <= r_buf1_addr;
            r_write_data <= r_buf1_data;
         end else if (w_grant0) begin
            r_write_addr <= r_buf0_addr;
            r_write_data <= r_buf0_data;
         end
      end
   end

   // Round-robin pointer: after any grant, priority moves to the other source.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_rr <= 1'b0;
      end else if (w_grant0) begin
         r_rr <= 1'b1;
      end else if (w_grant1) begin
         r_rr <= 1'b0;
      end
   end

   // Saturating count of cycles where both buffers compete.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_conflict_cnt <= '0;
      end else if (r_buf0_v && r_buf1_v && (r_conflict_cnt != {CNT_WIDTH{1'b1}})) begin
         r_conflict_cnt <= r_conflict_cnt + CNT_WIDTH'(1);
      end
   end

   // Pending-write bitmap: both buffers plus the active write stage; r0 never busy.
   always_comb begin
      w_busy = '0;
      if (r_buf0_v) w_busy[r_buf0_addr] = 1'b1;
      if (r_buf1_v) w_busy[r_buf1_addr] = 1'b1;
      if (r_reg_write) w_busy[r_write_addr] = 1'b1;
      w_busy[0] = 1'b0;
   end

   assign Busy          = w_busy;
   assign RegWrite      = r_reg_write;
   assign WriteAddr     = r_write_addr;
   assign WriteData     = r_write_data;
   assign ConflictCount = r_conflict_cnt;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: reset checks, a vector table covering single
// write / round robin / r0 drop, hand-written same-address and async-reset
// sequences, then random traffic against a transaction-level reference model.
module tb_regfile_write_arbiter;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        ReqValid0, ReqValid1;
   logic [4:0]  ReqAddr0, ReqAddr1;
   logic [31:0] ReqData0, ReqData1;
   logic        ReqReady0, ReqReady1;
   logic [4:0]  WriteAddr;
   logic [31:0] WriteData;
   logic        RegWrite;
   logic [31:0] Busy;
   logic [15:0] ConflictCount;

   // second instance with a tiny counter to observe saturation
   logic        s_rdy0, s_rdy1, s_we;
   logic [4:0]  s_wa;
   logic [31:0] s_wd, s_busy;
   logic [2:0]  s_cnt;

   int n_checks = 0;
   int n_errors = 0;

   regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(16)) u_dut (
      .Clock(Clock), .Reset(Reset),
      .ReqValid0(ReqValid0), .ReqAddr0(ReqAddr0), .ReqData0(ReqData0), .ReqReady0(ReqReady0),
      .ReqValid1(ReqValid1), .ReqAddr1(ReqAddr1), .ReqData1(ReqData1), .ReqReady1(ReqReady1),
      .WriteAddr(WriteAddr), .WriteData(WriteData), .RegWrite(RegWrite),
      .Busy(Busy), .ConflictCount(ConflictCount)
   );

   regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(3)) u_dut_sat (
      .Clock(Clock), .Reset(Reset),
      .ReqValid0(ReqValid0), .ReqAddr0(ReqAddr0), .ReqData0(ReqData0), .ReqReady0(s_rdy0),
      .ReqValid1(ReqValid1), .ReqAddr1(ReqAddr1), .ReqData1(ReqData1), .ReqReady1(s_rdy1),
      .WriteAddr(s_wa), .WriteData(s_wd), .RegWrite(s_we),
      .Busy(s_busy), .ConflictCount(s_cnt)
   );

   // clock
   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   logic        m_pv[2];
   logic [4:0]  m_pa[2];
   logic [31:0] m_pd[2];
   int          m_turn;      // source that wins a tie
   logic        m_we;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;
   int          m_conf;      // unsaturated conflict cycles
   logic [36:0] exp_q[$];    // {addr, data} writes expected at the write port

   function automatic int model_winner();
      if (m_pv[0] && m_pv[1]) return m_turn;
      if (m_pv[0]) return 0;
      if (m_pv[1]) return 1;
      return -1;
   endfunction

   function automatic logic model_ready(input int s);
      return !m_pv[s] || (model_winner() == s);
   endfunction

   function automatic logic [31:0] model_busy();
      logic [31:0] b;
      b = '0;
      for (int s = 0; s < 2; s++) if (m_pv[s]) b[m_pa[s]] = 1'b1;
      if (m_we) b[m_wa] = 1'b1;
      return b;
   endfunction

   task automatic model_reset();
      m_pv[0] = 0; m_pv[1] = 0;
      m_pa[0] = 0; m_pa[1] = 0;
      m_pd[0] = 0; m_pd[1] = 0;
      m_turn = 0; m_we = 0; m_wa = 0; m_wd = 0; m_conf = 0;
      exp_q.delete();
   endtask

   task automatic model_step(input logic iv0, input logic [4:0] ia0, input logic [31:0] id0,
                             input logic iv1, input logic [4:0] ia1, input logic [31:0] id1);
      int w;
      logic rdy[2];
      logic iv[2];
      logic [4:0] ia[2];
      logic [31:0] id[2];
      iv[0] = iv0; ia[0] = ia0; id[0] = id0;
      iv[1] = iv1; ia[1] = ia1; id[1] = id1;
      w = model_winner();
      rdy[0] = model_ready(0);
      rdy[1] = model_ready(1);
      if (m_pv[0] && m_pv[1]) m_conf++;
      if (w >= 0) begin
         m_we = 1; m_wa = m_pa[w]; m_wd = m_pd[w];
         exp_q.push_back({m_pa[w], m_pd[w]});
         m_turn = 1 - w;
         m_pv[w] = 0;
      end else begin
         m_we = 0;
      end
      for (int s = 0; s < 2; s++) begin
         if (iv[s] && rdy[s] && ia[s] != 0) begin
            m_pv[s] = 1; m_pa[s] = ia[s]; m_pd[s] = id[s];
         end
      end
   endtask

   // ---------------- driver helpers ----------------
   task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1);
      ReqValid0 = v0; ReqAddr0 = a0; ReqData0 = d0;
      ReqValid1 = v1; ReqAddr1 = a1; ReqData1 = d1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      model_reset();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic v0; logic [4:0] a0; logic [31:0] d0;
      logic v1; logic [4:0] a1; logic [31:0] d1;
      logic rdy0; logic rdy1;
      logic we; logic [4:0] wa; logic [31:0] wd;
      logic [31:0] busy; int conf;
   } vec_t;
   vec_t tq[$];

   task automatic add_vec(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                          input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                          input logic rdy0, input logic rdy1,
                          input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [31:0] busy, input int conf);
      vec_t v;
      v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
      v.rdy0 = rdy0; v.rdy1 = rdy1; v.we = we; v.wa = wa; v.wd = wd;
      v.busy = busy; v.conf = conf;
      tq.push_back(v);
   endtask

   // random-phase per-source held requests
   logic        hv[2];
   logic [4:0]  ha[2];
   logic [31:0] hd[2];

   task automatic compare_model(input string tag);
      logic [36:0] e;
      check({tag, " RegWrite"}, 64'(RegWrite), 64'(m_we));
      check({tag, " Busy"}, 64'(Busy), 64'(model_busy()));
      check({tag, " ConflictCount"}, 64'(ConflictCount), 64'((m_conf > 65535) ? 65535 : m_conf));
      if (RegWrite === 1'b1) begin
         if (exp_q.size() == 0) begin
            check({tag, " unexpected write"}, 64'({WriteAddr, WriteData}), 64'h0);
         end else begin
            e = exp_q.pop_front();
            check({tag, " write"}, 64'({WriteAddr, WriteData}), 64'(e));
         end
      end
   endtask

   initial begin
      Reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);

      // ---- reset then idle ----
      do_reset();
      check("reset RegWrite", 64'(RegWrite), 64'h0);
      check("reset Busy", 64'(Busy), 64'h0);
      check("reset ReqReady0", 64'(ReqReady0), 64'h1);
      check("reset ReqReady1", 64'(ReqReady1), 64'h1);
      check("reset ConflictCount", 64'(ConflictCount), 64'h0);
      check("reset WriteAddr", 64'(WriteAddr), 64'h0);

      // ---- table: single write, round robin, r0 drop ----
      add_vec(1, 5, 32'hDEADBEEF, 0, 0, 0,            1, 1, 0, 0, 32'h0,        32'h20, 0);
      add_vec(0, 0, 0,            0, 0, 0,            1, 1, 1, 5, 32'hDEADBEEF, 32'h20, 0);
      add_vec(0, 0, 0,            0, 0, 0,            1, 1, 0, 5, 32'hDEADBEEF, 32'h0,  0);
      add_vec(1, 3, 32'hA0,       1, 7, 32'hB0,       1, 1, 0, 5, 32'hDEADBEEF, 32'h88, 0);
      add_vec(1, 3, 32'hA1,       1, 7, 32'hB1,       0, 1, 1, 7, 32'hB0,       32'h88, 1);
      add_vec(1, 3, 32'hA1,       1, 7, 32'hB2,       1, 0, 1, 3, 32'hA0,       32'h88, 2);
      add_vec(1, 3, 32'hA2,       1, 7, 32'hB2,       0, 1, 1, 7, 32'hB1,       32'h88, 3);
      add_vec(1, 3, 32'hA2,       0, 0, 0,            1, 0, 1, 3, 32'hA1,       32'h88, 4);
      add_vec(0, 0, 0,            0, 0, 0,            0, 1, 1, 7, 32'hB2,       32'h88, 5);
      add_vec(0, 0, 0,            0, 0, 0,            1, 1, 1, 3, 32'hA2,       32'h08, 5);
      add_vec(0, 0, 0,            0, 0, 0,            1, 1, 0, 3, 32'hA2,       32'h0,  5);
      add_vec(0, 0, 0,            1, 0, 32'h12345678, 1, 1, 0, 3, 32'hA2,       32'h0,  5);
      add_vec(0, 0, 0,            0, 0, 0,            1, 1, 0, 3, 32'hA2,       32'h0,  5);
      for (int i = 0; i < tq.size(); i++) begin
         drive(tq[i].v0, tq[i].a0, tq[i].d0, tq[i].v1, tq[i].a1, tq[i].d1);
         #1;
         check($sformatf("vec%0d ReqReady0", i), 64'(ReqReady0), 64'(tq[i].rdy0));
         check($sformatf("vec%0d ReqReady1", i), 64'(ReqReady1), 64'(tq[i].rdy1));
         @(posedge Clock);
         @(negedge Clock);
         check($sformatf("vec%0d RegWrite", i), 64'(RegWrite), 64'(tq[i].we));
         check($sformatf("vec%0d WriteAddr", i), 64'(WriteAddr), 64'(tq[i].wa));
         check($sformatf("vec%0d WriteData", i), 64'(WriteData), 64'(tq[i].wd));
         check($sformatf("vec%0d Busy", i), 64'(Busy), 64'(tq[i].busy));
         check($sformatf("vec%0d ConflictCount", i), 64'(ConflictCount), 64'(tq[i].conf));
      end
      drive(0, 0, 0, 0, 0, 0);

      // ---- same address from both sources, Rr=0 after reset ----
      do_reset();
      drive(1, 9, 32'h1, 1, 9, 32'h2);
      #1;
      check("same ReqReady0", 64'(ReqReady0), 64'h1);
      check("same ReqReady1", 64'(ReqReady1), 64'h1);
      @(posedge Clock); @(negedge Clock);
      drive(0, 0, 0, 0, 0, 0);
      check("same buffered RegWrite", 64'(RegWrite), 64'h0);
      check("same buffered Busy", 64'(Busy), 64'h200);
      @(posedge Clock); @(negedge Clock);
      check("same first write", 64'({RegWrite, WriteAddr, WriteData}), 64'({1'b1, 5'd9, 32'h1}));
      check("same first Busy", 64'(Busy), 64'h200);
      @(posedge Clock); @(negedge Clock);
      check("same second write", 64'({RegWrite, WriteAddr, WriteData}), 64'({1'b1, 5'd9, 32'h2}));
      check("same second Busy", 64'(Busy), 64'h200);
      @(posedge Clock); @(negedge Clock);
      check("same done RegWrite", 64'(RegWrite), 64'h0);
      check("same done Busy", 64'(Busy), 64'h0);

      // ---- asynchronous reset with both buffers full and a write in flight ----
      do_reset();
      drive(1, 3, 32'h33, 1, 7, 32'h77);
      @(posedge Clock); @(negedge Clock);
      drive(1, 4, 32'h44, 1, 7, 32'h77);
      @(posedge Clock); @(negedge Clock);
      drive(0, 0, 0, 0, 0, 0);
      check("pre-reset RegWrite", 64'(RegWrite), 64'h1);
      check("pre-reset Busy", 64'(Busy), 64'h98);
      #2 Reset = 1'b1;
      #1;
      check("async RegWrite", 64'(RegWrite), 64'h0);
      check("async Busy", 64'(Busy), 64'h0);
      check("async WriteAddr", 64'(WriteAddr), 64'h0);
      check("async WriteData", 64'(WriteData), 64'h0);
      check("async ConflictCount", 64'(ConflictCount), 64'h0);
      check("async ReqReady", 64'({ReqReady0, ReqReady1}), 64'h3);
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge Clock); @(negedge Clock);
         check($sformatf("post-reset%0d RegWrite", i), 64'(RegWrite), 64'h0);
         check($sformatf("post-reset%0d Busy", i), 64'(Busy), 64'h0);
      end

      // ---- random traffic against the reference model ----
      do_reset();
      hv[0] = 0; hv[1] = 0;
      for (int c = 0; c < 600; c++) begin
         for (int s = 0; s < 2; s++) begin
            if (!hv[s]) begin
               hv[s] = ($urandom_range(0, 99) < 65);
               ha[s] = 5'($urandom_range(0, 7));
               hd[s] = $urandom;
            end
         end
         drive(hv[0], ha[0], hd[0], hv[1], ha[1], hd[1]);
         #1;
         check("rand ReqReady0", 64'(ReqReady0), 64'(model_ready(0)));
         check("rand ReqReady1", 64'(ReqReady1), 64'(model_ready(1)));
         if (hv[0] && model_ready(0)) hv[0] = 0;
         else if (model_ready(0)) hv[0] = 0;
         if (hv[1] && model_ready(1)) hv[1] = 0;
         else if (model_ready(1)) hv[1] = 0;
         model_step(ReqValid0, ReqAddr0, ReqData0, ReqValid1, ReqAddr1, ReqData1);
         @(posedge Clock); @(negedge Clock);
         compare_model("rand");
      end
      drive(0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 4; c++) begin
         model_step(0, 0, 0, 0, 0, 0);
         @(posedge Clock); @(negedge Clock);
         compare_model("drain");
      end
      check("drain queue empty", 64'(exp_q.size()), 64'h0);
      check("saturating ConflictCount", 64'(s_cnt), 64'((m_conf > 7) ? 7 : m_conf));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (WriteAddr/WriteData/RegWrite) between two writeback requesters: source 0 (ALU) and source 1 (memory/load).
- Each source has a valid/ready handshake and a one-entry holding buffer.
- Buffered entries are granted round-robin to a registered write stage.
- A pending-write bitmap is exported so decode logic can stall on register hazards.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 5, register address width; the register count is 2**ADDR_WIDTH.
- CNT_WIDTH, 16, width of the saturating conflict counter.

Ports:
- Clock  in  1  single system clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- ReqValid0  in  1  source 0 has a write request.
- ReqAddr0  in  ADDR_WIDTH  source 0 destination register.
- ReqData0  in  DATA_WIDTH  source 0 write data.
- ReqReady0  out  1  source 0 request accepted this cycle if ReqValid0=1.
- ReqValid1 / ReqAddr1 / ReqData1 / ReqReady1  same as source 0, for source 1.
- WriteAddr  out  ADDR_WIDTH  to register file write address.
- WriteData  out  DATA_WIDTH  to register file write data.
- RegWrite  out  1  to register file write enable; one-cycle pulse per granted write.
- Busy  out  2**ADDR_WIDTH  bit r = 1 while a write to register r is buffered or in the output stage.
- ConflictCount  out  CNT_WIDTH  cycles in which both buffers held entries; saturates.

Behaviour:
- State:
  - Buf0 and Buf1, each holding {valid, addr, data}.
  - Output stage {RegWrite, WriteAddr, WriteData}.
  - Round-robin pointer Rr: 0 means source 0 has priority.
  - ConflictCount.
- Reset values (asynchronous, effective while Reset=1):
  - Buf0.valid = Buf1.valid = 0.
  - Rr = 0.
  - RegWrite = 0, WriteAddr = 0, WriteData = 0.
  - ConflictCount = 0.
  - As a result, ReqReady0 = ReqReady1 = 1 and Busy = 0.
  - Reset mid-operation discards buffered and in-flight writes; no RegWrite pulse is issued for them.
- Arbitration (combinational, from buffer state only):
  - Both buffers valid: grant the source selected by Rr; Rr toggles to the other source at the next edge.
  - Exactly one buffer valid: grant it; Rr is set to the other source.
  - Neither valid: no grant; Rr unchanged.
- Ready:
  - ReqReadyi = !Bufi.valid || granti.
  - No combinational path from ReqValid or ReqAddr to ReqReady.
- Accept:
  - On posedge with ReqValidi && ReqReadyi, Bufi loads the request.
  - Exception: ReqAddri == 0. The handshake completes but the buffer is not loaded (write to r0 is dropped), Bufi.valid goes to 0 if its entry was granted, and Busy[0] is never set.
- Granted entry:
  - Copied into the output stage at posedge; RegWrite = 1 for exactly that next cycle.
  - The register file captures the write at the following posedge.
- Latency:
  - Request accepted at edge N into an idle arbiter: RegWrite high in cycle N+1..N+2; register written at edge N+2.
  - A losing source waits one extra cycle per competing grant.
- Throughput:
  - One write per cycle sustained.
  - A source whose entry is granted may present a new request in the same cycle with no bubble.
- RegWrite is 0 in every cycle without a grant in the preceding cycle; WriteAddr/WriteData hold their last values.
- Busy = OR of decoded addresses of valid Buf0, valid Buf1, and the output stage when RegWrite=1. Bit 0 is always 0.
- Same address from both sources in flight: both writes are issued, ordered by Rr; the later grant wins in the register file.
- ConflictCount increments on every posedge where Buf0.valid && Buf1.valid, and stops at 2**CNT_WIDTH-1.

Test Plan:
- Reset, then idle: Reset=1 for 2 cycles, release -> RegWrite=0, Busy=0, ReqReady0=ReqReady1=1, ConflictCount=0.
- Single write: source 0 sends addr 5, data 0xDEADBEEF at edge N -> Busy[5]=1 in cycles N..N+2; RegWrite=1 with WriteAddr=5, WriteData=0xDEADBEEF in cycle N+1; Busy[5]=0 after edge N+2.
- Round robin: both sources valid every cycle with addrs 3 (src0) and 7 (src1) -> RegWrite stays high continuously; WriteAddr sequence 3,7,3,7…; ConflictCount increments each cycle.
- Zero register: source 1 sends addr 0, data 0x12345678 -> ReqReady1=1, no RegWrite pulse, Busy=0 throughout.
- Same address: src0 addr 9 data 0x1, src1 addr 9 data 0x2 at the same edge with Rr=0 -> writes issued 0x1 then 0x2; Busy[9] clears only after the second write.
- Reset mid-operation: assert Reset asynchronously while both buffers are full -> outputs and Busy go to 0 immediately, without waiting for a clock edge; no further RegWrite pulses occur after release.
